mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipelined CPU.
- Consumes the EX/MEM register outputs. Performs the data-RAM or peripheral access and resolves the write-back value using MemtoReg.
- Registers the result into the MEM/WB boundary and drives the register-file write port in the next cycle.
- Contains the memory-mapped timer, LED, digit and systick peripherals, and raises the timer interrupt request.

Parameters:
- RAM_WORDS, 256, data RAM depth in 32-bit words; must be a power of two.
- RAM_AW, 8, log2(RAM_WORDS); word-index bits taken from ALUOuti[RAM_AW+1:2].

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- RegWri  in  1  register write enable from EX/MEM
- MemReadi  in  1  load enable
- MemWri  in  1  store enable
- MemtoRegi  in  2  write-back select: 0 ALU result, 1 load data, 2 PC+4, 3 treated as 0
- PCi  in  32  instruction PC
- RegAddri  in  5  destination register
- RegDatai  in  32  store data
- ALUOuti  in  32  byte address or ALU result
- loadbytei  in  1  1 = lb (byte load, sign-extended), 0 = lw
- RegWro  out  1  MEM/WB register write enable
- RegAddro  out  5  MEM/WB destination register
- WBDatao  out  32  MEM/WB write-back data
- fwd_data  out  32  combinational write-back value of the current MEM instruction, for the forwarding unit
- irq  out  1  timer interrupt request (TCON[2])
- leds  out  8  LED register
- digi  out  12  seven-segment register

Behaviour:
- Reset (asynchronous):
  - RegWro=0, RegAddro=0, WBDatao=0.
  - TH=0, TL=0, TCON=0, LED=0, DIGI=0, SYSTICK=0.
  - RAM contents are not reset.
- Address map:
  - RAM at 0x00000000 to 4*RAM_WORDS-1.
  - 0x40000000 TH, 0x40000004 TL, 0x40000008 TCON[2:0] (bit0 enable, bit1 irq-enable, bit2 irq-status).
  - 0x4000000C LED[7:0], 0x40000010 DIGI[11:0], 0x40000014 SYSTICK (read-only).
  - Any other address reads 0 and ignores writes.
- Reads: combinational, same cycle.
  - Narrow registers are zero-extended.
  - ALUOuti[1:0] is ignored for word reads.
- Byte load (lb): byte lane = ALUOuti[1:0], little-endian (00 selects bits 7:0). Result is sign-extended to 32 bits. Applies to RAM and peripherals alike.
- Stores: word only, committed on the rising edge when MemWri=1.
  - A store to RAM is visible to a load in the following cycle.
  - A store to SYSTICK is ignored.
  - A store to TCON writes all 3 bits, so the CPU can clear irq-status.
- If MemReadi=0, load data is 0.
- fwd_data is selected by MemtoRegi: ALUOuti, load data, PCi+4 (mod 2^32), or ALUOuti for code 3.
- MEM/WB register: every rising edge, RegWro<=RegWri, RegAddro<=RegAddri, WBDatao<=fwd_data. Latency is one cycle. No stall or flush inputs; bubbles arrive as RegWri=0.
- Timer, per cycle while TCON[0]=1:
  - If TL==0xFFFFFFFF: TL<=TH, and TCON[2]<=1 when TCON[1]=1.
  - Otherwise TL<=TL+1.
  - While TCON[0]=0, TL holds.
- Simultaneous events:
  - A CPU store to TL or TCON in the same cycle as a timer update wins; the timer update is dropped that cycle.
  - A store to TH during a reload: TL takes the old TH.
- SYSTICK increments every cycle and wraps from 0xFFFFFFFF to 0.
- irq = TCON[2], held until software clears it.
- Reset asserted mid-operation:
  - Any in-flight store is lost.
  - Outputs go to reset values immediately, not at the clock edge.

Decomposition:
- Shared package/header:
  - Peripheral address constants (ADDR_TH, ADDR_TL, ADDR_TCON, ADDR_LED, ADDR_DIGI, ADDR_SYSTICK).
  - MemtoReg encodings (WB_ALU=0, WB_MEM=1, WB_PC4=2).
  - TCON bit indices.
- One sub-module, periph_timer: TH/TL/TCON/SYSTICK state, read mux and irq. RAM and MEM/WB register stay in mem_stage.

Test Plan:
- Reset mid-run with RegWri=1 -> RegWro=0, WBDatao=0, irq=0, leds=0 asynchronously before the next clock edge.
- Store 0x80FF1234 to addr 0x10, then lw 0x10 with MemtoReg=1, RegAddr=5 -> next cycle RegWro=1, RegAddro=5, WBDatao=0x80FF1234.
- lb at 0x11 and at 0x13 after that store -> WBDatao=0x00000012, then 0xFFFFFF80.
- MemtoReg=2, PCi=0x0040001C -> WBDatao=0x00400020. MemtoReg=0, ALUOuti=7 -> WBDatao=7.
- Timer reload and interrupt:
  - Stimulus: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3.
  - TL sequence: 0xFFFFFFFF, then 0xFFFFFFFD (reload), at which point irq=1.
  - Store TCON=1 -> irq=0 and counting continues.
- Store to TL in the same cycle the timer would increment -> TL equals the stored value. Load 0x40000020 -> 0. Store to 0x40000020 -> no state change.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: peripheral address map, write-back
// select encodings and TCON bit positions.
package mem_stage_pkg;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGI    = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    // Peripherals are word registers, so the byte-lane bits never take part in decode.
    function automatic logic hitWord(input logic [31:2] wordAddr, input logic [31:0] base);
        return {wordAddr, 2'b00} == base;
    endfunction

endpackage

// File: rtl/mem_stage_periph_timer.sv
// Memory-mapped peripherals: reloading timer with interrupt, LED and digit
// registers, free-running systick, plus their word read mux.
module periph_timer
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata_o,
    output logic        irq_o,
    output logic [7:0]  leds_o,
    output logic [11:0] digi_o
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [31:0] systick_q;
    logic        wrTh, wrTl, wrTcon, wrLed, wrDigi;

    always_comb begin
        wrTh   = we_i && hitWord(addr_i, ADDR_TH);
        wrTl   = we_i && hitWord(addr_i, ADDR_TL);
        wrTcon = we_i && hitWord(addr_i, ADDR_TCON);
        wrLed  = we_i && hitWord(addr_i, ADDR_LED);
        wrDigi = we_i && hitWord(addr_i, ADDR_DIGI);
    end

    // A CPU store to TL or TCON suppresses the whole timer update for that cycle;
    // a TH store during reload still lets TL pick up the old TH.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;
        if (tcon_q[TCON_EN] && !(wrTl || wrTcon)) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) begin
                    tcon_d[TCON_IS] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wrTh)   th_d   = wdata_i;
        if (wrTl)   tl_d   = wdata_i;
        if (wrTcon) tcon_d = wdata_i[2:0];
        if (wrLed)  led_d  = wdata_i[7:0];
        if (wrDigi) digi_d = wdata_i[11:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_q + 32'd1;
        end
    end

    always_comb begin
        rdata_o = '0;
        if      (hitWord(addr_i, ADDR_TH))      rdata_o = th_q;
        else if (hitWord(addr_i, ADDR_TL))      rdata_o = tl_q;
        else if (hitWord(addr_i, ADDR_TCON))    rdata_o = {29'd0, tcon_q};
        else if (hitWord(addr_i, ADDR_LED))     rdata_o = {24'd0, led_q};
        else if (hitWord(addr_i, ADDR_DIGI))    rdata_o = {20'd0, digi_q};
        else if (hitWord(addr_i, ADDR_SYSTICK)) rdata_o = systick_q;
    end

    assign irq_o  = tcon_q[TCON_IS];
    assign leds_o = led_q;
    assign digi_o = digi_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: data RAM, peripheral access, write-back
// select and the MEM/WB pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int RAM_AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWri,
    input  logic        MemReadi,
    input  logic        MemWri,
    input  logic [1:0]  MemtoRegi,
    input  logic [31:0] PCi,
    input  logic [4:0]  RegAddri,
    input  logic [31:0] RegDatai,
    input  logic [31:0] ALUOuti,
    input  logic        loadbytei,
    output logic        RegWro,
    output logic [4:0]  RegAddro,
    output logic [31:0] WBDatao,
    output logic [31:0] fwd_data,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [11:0] digi
);

    logic [31:0]       ram_q [RAM_WORDS];
    logic              ramSel;
    logic [RAM_AW-1:0] ramIdx;
    logic [31:0]       periphRdata;
    logic [31:0]       loadWord;
    logic [7:0]        loadByte;
    logic [31:0]       loadData;

    assign ramSel = (ALUOuti[31:RAM_AW+2] == '0);
    assign ramIdx = ALUOuti[RAM_AW+1:2];

    always_ff @(posedge clk) begin
        if (MemWri && ramSel) begin
            ram_q[ramIdx] <= RegDatai;
        end
    end

    periph_timer u_periph (
        .clk     (clk),
        .reset   (reset),
        .addr_i  (ALUOuti[31:2]),
        .wdata_i (RegDatai),
        .we_i    (MemWri),
        .rdata_o (periphRdata),
        .irq_o   (irq),
        .leds_o  (leds),
        .digi_o  (digi)
    );

    // Byte lane is little-endian and applies equally to RAM and peripheral words.
    always_comb begin
        loadWord = ramSel ? ram_q[ramIdx] : periphRdata;
        loadByte = loadWord[{ALUOuti[1:0], 3'b000} +: 8];
        loadData = '0;
        if (MemReadi) begin
            loadData = loadbytei ? {{24{loadByte[7]}}, loadByte} : loadWord;
        end
    end

    always_comb begin
        case (MemtoRegi)
            WB_MEM:  fwd_data = loadData;
            WB_PC4:  fwd_data = PCi + 32'd4;
            default: fwd_data = ALUOuti;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWro   <= 1'b0;
            RegAddro <= '0;
            WBDatao  <= '0;
        end else begin
            RegWro   <= RegWri;
            RegAddro <= RegAddri;
            WBDatao  <= fwd_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios plus random traffic,
// checked against an address-map level model of RAM and peripherals.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWri, MemReadi, MemWri, loadbytei;
    logic [1:0]  MemtoRegi;
    logic [31:0] PCi, RegDatai, ALUOuti;
    logic [4:0]  RegAddri;
    logic        RegWro;
    logic [4:0]  RegAddro;
    logic [31:0] WBDatao, fwd_data;
    logic        irq;
    logic [7:0]  leds;
    logic [11:0] digi;

    mem_stage #(.RAM_WORDS(256), .RAM_AW(8)) dut (
        .clk(clk), .reset(reset), .RegWri(RegWri), .MemReadi(MemReadi), .MemWri(MemWri),
        .MemtoRegi(MemtoRegi), .PCi(PCi), .RegAddri(RegAddri), .RegDatai(RegDatai),
        .ALUOuti(ALUOuti), .loadbytei(loadbytei), .RegWro(RegWro), .RegAddro(RegAddro),
        .WBDatao(WBDatao), .fwd_data(fwd_data), .irq(irq), .leds(leds), .digi(digi)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_TH = 32'h4000_0000, A_TL = 32'h4000_0004, A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED = 32'h4000_000C, A_DIGI = 32'h4000_0010, A_SYS = 32'h4000_0014;
    localparam logic [31:0] A_BAD = 32'h4000_0020;

    typedef struct packed {
        logic        regWr;
        logic [4:0]  regAddr;
        logic [31:0] wbData;
        logic        irq;
        logic [7:0]  leds;
        logic [11:0] digi;
    } expT;

    expT sbQ[$];
    expT monE;
    int  total = 0;
    int  bad = 0;

    logic [31:0] mRam [256];
    logic [31:0] mTh, mTl, mSys;
    logic [2:0]  mTcon;
    logic [7:0]  mLed;
    logic [11:0] mDigi;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mTh = 0; mTl = 0; mTcon = 0; mLed = 0; mDigi = 0; mSys = 0;
    endfunction

    function automatic logic [31:0] modelWord(input logic [31:0] addr);
        logic [31:0] w;
        w = addr & 32'hFFFF_FFFC;
        if (addr < 32'd1024) return mRam[addr[9:2]];
        case (w)
            A_TH:    return mTh;
            A_TL:    return mTl;
            A_TCON:  return {29'd0, mTcon};
            A_LED:   return {24'd0, mLed};
            A_DIGI:  return {20'd0, mDigi};
            A_SYS:   return mSys;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic lb);
        logic [31:0] w;
        logic [7:0]  b;
        w = modelWord(addr);
        if (!lb) return w;
        b = 8'((w >> (8 * addr[1:0])) & 32'hFF);
        return {{24{b[7]}}, b};
    endfunction

    function automatic void modelStep(input logic we, input logic [31:0] addr, input logic [31:0] d);
        logic [31:0] w;
        logic        cpuOwnsTimer;
        w = addr & 32'hFFFF_FFFC;
        cpuOwnsTimer = we && (w == A_TL || w == A_TCON);
        if (mTcon[0] && !cpuOwnsTimer) begin
            if (mTl == 32'hFFFF_FFFF) begin
                mTl = mTh;
                if (mTcon[1]) mTcon[2] = 1'b1;
            end else begin
                mTl = mTl + 1;
            end
        end
        if (we) begin
            if (addr < 32'd1024) mRam[addr[9:2]] = d;
            else begin
                case (w)
                    A_TH:    mTh = d;
                    A_TL:    mTl = d;
                    A_TCON:  mTcon = d[2:0];
                    A_LED:   mLed = d[7:0];
                    A_DIGI:  mDigi = d[11:0];
                    default: ;
                endcase
            end
        end
        mSys = mSys + 1;
    endfunction

    // Drives one cycle at a falling edge; the following rising edge is the one modelled.
    task automatic applyStimulus(input logic regWr, input logic memRd, input logic memWr,
                                 input logic [1:0] m2r, input logic [31:0] pc, input logic [4:0] rd,
                                 input logic [31:0] wdata, input logic [31:0] addr, input logic lb);
        expT e;
        logic [31:0] ld, wb;
        RegWri = regWr; MemReadi = memRd; MemWri = memWr; MemtoRegi = m2r;
        PCi = pc; RegAddri = rd; RegDatai = wdata; ALUOuti = addr; loadbytei = lb;
        ld = memRd ? modelLoad(addr, lb) : 32'd0;
        case (m2r)
            2'd1:    wb = ld;
            2'd2:    wb = pc + 32'd4;
            default: wb = addr;
        endcase
        modelStep(memWr, addr, wdata);
        e.regWr = regWr; e.regAddr = rd; e.wbData = wb;
        e.irq = mTcon[2]; e.leds = mLed; e.digi = mDigi;
        sbQ.push_back(e);
        @(negedge clk);
    endtask

    task automatic doStore(input logic [31:0] addr, input logic [31:0] d);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'h100, 5'd0, d, addr, 1'b0);
    endtask

    task automatic doLoad(input logic [31:0] addr, input logic lb, input logic [4:0] rd);
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 32'h200, rd, 32'hDEAD_BEEF, addr, lb);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sbQ.size() > 0) begin
            monE = sbQ.pop_front();
            checkOutput("RegWro", 32'(RegWro), 32'(monE.regWr));
            checkOutput("RegAddro", 32'(RegAddro), 32'(monE.regAddr));
            checkOutput("WBDatao", WBDatao, monE.wbData);
            checkOutput("irq", 32'(irq), 32'(monE.irq));
            checkOutput("leds", 32'(leds), 32'(monE.leds));
            checkOutput("digi", 32'(digi), 32'(monE.digi));
        end
    end

    initial begin
        logic [31:0] a, d;
        int          kind;
        reset = 1'b1;
        RegWri = 0; MemReadi = 0; MemWri = 0; MemtoRegi = 0; PCi = 0;
        RegAddri = 0; RegDatai = 0; ALUOuti = 0; loadbytei = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("reset_RegWro", 32'(RegWro), 32'd0);
        checkOutput("reset_WBDatao", WBDatao, 32'd0);
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_leds", 32'(leds), 32'd0);

        for (int i = 0; i < 256; i++) doStore(32'(i * 4), $urandom);

        doStore(32'h10, 32'h80FF_1234);
        doLoad(32'h10, 1'b0, 5'd5);
        doLoad(32'h11, 1'b1, 5'd6);
        doLoad(32'h13, 1'b1, 5'd7);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 32'h0040_001C, 5'd1, 32'h0, 32'h55, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 5'd2, 32'h0, 32'h7, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd3, 32'h0, 5'd3, 32'h0, 32'h1234, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 32'h0, 5'd4, 32'h0, 32'h10, 1'b0);
        doStore(A_LED, 32'hFFFF_FFA5);
        doStore(A_DIGI, 32'h1234_5ABC);
        doLoad(A_LED, 1'b0, 5'd8);
        doLoad(A_DIGI + 32'd1, 1'b1, 5'd9);
        doLoad(A_SYS, 1'b0, 5'd10);
        doStore(A_SYS, 32'h0);
        doLoad(A_SYS, 1'b0, 5'd10);

        doStore(A_TH, 32'hFFFF_FFFD);
        doStore(A_TL, 32'hFFFF_FFFE);
        doStore(A_TCON, 32'h3);
        repeat (4) doLoad(A_TL, 1'b0, 5'd11);
        doStore(A_TCON, 32'h1);
        repeat (2) doLoad(A_TL, 1'b0, 5'd12);
        doStore(A_TL, 32'h1234_5678);
        doLoad(A_TL, 1'b0, 5'd13);
        doStore(A_TL, 32'hFFFF_FFFF);
        doStore(A_TH, 32'h0000_0055);
        doLoad(A_TL, 1'b0, 5'd14);
        doLoad(A_TH, 1'b0, 5'd15);
        doLoad(A_BAD, 1'b0, 5'd16);
        doLoad(A_BAD + 32'd3, 1'b1, 5'd16);
        doStore(A_BAD, 32'hFFFF_FFFF);
        doLoad(A_TCON, 1'b0, 5'd17);
        doLoad(32'h400, 1'b0, 5'd18);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd1, 32'h0, 5'd19, 32'h0, 32'h10, 1'b0);

        doStore(A_TL, 32'hFFFF_FFFE);
        doStore(A_TCON, 32'h3);
        repeat (3) idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 5'd20, 32'h0, 32'h77, 1'b0);

        RegWri = 1; MemWri = 1; MemReadi = 0; MemtoRegi = 0;
        ALUOuti = A_LED; RegDatai = 32'h3C; RegAddri = 5'd9;
        #2 reset = 1'b1;
        #1;
        checkOutput("async_RegWro", 32'(RegWro), 32'd0);
        checkOutput("async_RegAddro", 32'(RegAddro), 32'd0);
        checkOutput("async_WBDatao", WBDatao, 32'd0);
        checkOutput("async_irq", 32'(irq), 32'd0);
        checkOutput("async_leds", 32'(leds), 32'd0);
        @(negedge clk);
        checkOutput("lost_store_leds", 32'(leds), 32'd0);
        RegWri = 0; MemWri = 0;
        reset = 1'b0;
        modelReset();

        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: a = $urandom_range(0, 1023);
                1: a = A_TH + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
                2: a = (i % 2 == 0) ? A_BAD : 32'h0000_0400 + 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 1023));
            endcase
            d = $urandom;
            if ((a & 32'hFFFF_FFFC) == A_TL) d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            if (kind == 3 || (kind == 1 && $urandom_range(0, 2) == 0))
                applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, $urandom, 5'($urandom), d, a, 1'b0);
            else
                applyStimulus(1'($urandom), 1'($urandom), 1'b0, 2'($urandom), $urandom,
                              5'($urandom), d, a, 1'($urandom));
        end

        for (int i = 0; i < 5 && sbQ.size() > 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
